led_array_ctrl: RTL

- Parametrised successor to the per-bit LED driver array: NCH channels, each with a runtime-programmable mode instead of a fixed elaboration-time MODE.
- Modes per channel: off, inverted follow, blink, PWM dimming.
- Shared prescaler and PWM counter drive all channels; a simple write-only config port programs mode and duty per channel.
- Sits between status/VAL logic and the board LED pins.

---
 rtl/led_array_ctrl_if.sv | 28 ++
 rtl/led_array_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/led_array_ctrl_if.sv
// Config write port for led_array_ctrl.
// Master drives writes; slave answers with CFG_ERR.
interface led_array_ctrl_if #(
  parameter int CH_W  = 2,
  parameter int PWM_W = 8
);
  logic             CFG_WE;
  logic [CH_W-1:0]  CFG_CH;
  logic [1:0]       CFG_MODE;
  logic [PWM_W-1:0] CFG_DUTY;
  logic             CFG_ERR;

  modport master (
    output CFG_WE,
    output CFG_CH,
    output CFG_MODE,
    output CFG_DUTY,
    input  CFG_ERR
  );

  modport slave (
    input  CFG_WE,
    input  CFG_CH,
    input  CFG_MODE,
    input  CFG_DUTY,
    output CFG_ERR
  );
endinterface

// File: rtl/led_array_ctrl.sv
// Multi-channel LED driver: off / inverted follow / blink / PWM per channel,
// sharing one prescaler, PWM counter and blink phase.
module led_array_ctrl #(
  parameter int          NCH      = 4,
  parameter int          PWM_W    = 8,
  parameter int          PRE_W    = 4,
  parameter logic [1:0]  DEF_MODE = 2'd1,
  localparam int         CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NCH-1:0]  VAL,
  led_array_ctrl_if.slave cfg,
  output logic            TICK,
  output logic [NCH-1:0]  LED
);

  logic             pre_wrap;
  logic             tick_d, tick_q;
  logic [PWM_W-1:0] pwm_d, pwm_q;
  logic             phase_d, phase_q;
  logic             err_d, err_q;
  logic [CH_W-1:0]  ch;
  logic             ch_ok;

  assign ch = cfg.CFG_CH;

  // PRE_W=0 has no prescaler: every clock is a tick.
  if (PRE_W > 0) begin : g_pre
    logic [PRE_W-1:0] pre_d, pre_q;

    always_comb begin
      pre_d = pre_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_d;
      end
    end

    assign pre_wrap = &pre_q;
  end else begin : g_nopre
    assign pre_wrap = 1'b1;
  end

  always_comb begin
    tick_d  = pre_wrap;
    pwm_d   = pwm_q;
    phase_d = phase_q;
    if (pre_wrap) begin
      pwm_d = pwm_q + 1'b1;
      if (&pwm_q) begin
        phase_d = ~phase_q;
      end
    end
    ch_ok = 32'(ch) < NCH;
    err_d = cfg.CFG_WE && !ch_ok;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_q  <= 1'b0;
      pwm_q   <= '0;
      phase_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      pwm_q   <= pwm_d;
      phase_q <= phase_d;
      err_q   <= err_d;
    end
  end

  assign TICK        = tick_q;
  assign cfg.CFG_ERR = err_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic             wr;
    logic [1:0]       mode_d, mode_q;
    logic [PWM_W-1:0] duty_d, duty_q;
    logic             led_d, led_q;

    always_comb begin
      wr     = cfg.CFG_WE && (ch == CH_W'(i));
      mode_d = wr ? cfg.CFG_MODE : mode_q;
      duty_d = wr ? cfg.CFG_DUTY : duty_q;
      led_d  = 1'b0;
      unique case (mode_q)
        2'd0: led_d = 1'b0;
        2'd1: led_d = ~VAL[i];
        2'd2: led_d = VAL[i] & phase_q;
        2'd3: led_d = VAL[i] & (pwm_q < duty_q);
        default: led_d = 1'b0;
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        mode_q <= DEF_MODE;
        duty_q <= '0;
        led_q  <= 1'b0;
      end else begin
        mode_q <= mode_d;
        duty_q <= duty_d;
        led_q  <= led_d;
      end
    end

    assign LED[i] = led_q;
  end

endmodule
